// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, checksummed little-endian byte stream into instruction memory; holds the core until done.
// One write per word, registered one cycle after its 4th byte; in_ready is low outside HDR/DATA/CSUM, so the source stalls.
module imem_boot_loader #(
  parameter int Size = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IW = $clog2(Size) + 1;

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t          state;
  logic [1:0]      bcnt;
  logic [31:0]     nwords;
  logic [23:0]     asm_q;
  logic [7:0]      sum;
  logic [IW-1:0]   widx;

  logic            xfer;
  logic [31:0]     hdr_full;
  logic [IW-1:0]   widx_nxt;

  assign xfer     = in_valid && in_ready;
  assign hdr_full = {in_data, nwords[23:0]};
  assign widx_nxt = widx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= INIT;
      bcnt     <= 2'd0;
      nwords   <= 32'd0;
      asm_q    <= 24'd0;
      sum      <= 8'd0;
      widx     <= '0;
      in_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= 32'd0;
      wdata    <= 32'd0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        INIT: begin
          state    <= HDR;
          in_ready <= 1'b1;
        end

        HDR: begin
          if (xfer) begin
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: nwords[7:0]   <= in_data;
              2'd1: nwords[15:8]  <= in_data;
              2'd2: nwords[23:16] <= in_data;
              default: begin
                nwords <= hdr_full;
                widx   <= '0;
                sum    <= 8'd0;
                if (hdr_full > 32'(Size)) begin
                  state    <= ERROR;
                  in_ready <= 1'b0;
                  error    <= 1'b1;
                end else if (hdr_full == 32'd0) begin
                  state <= CSUM;
                end else begin
                  state <= DATA;
                end
              end
            endcase
          end
        end

        DATA: begin
          if (xfer) begin
            sum  <= sum + in_data;
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: asm_q[7:0]   <= in_data;
              2'd1: asm_q[15:8]  <= in_data;
              2'd2: asm_q[23:16] <= in_data;
              default: begin
                we    <= 1'b1;
                wdata <= {in_data, asm_q};
                waddr <= 32'({widx, 2'b00});
                widx  <= widx_nxt;
                // nwords <= Size here, so the index comparison cannot overflow
                if (32'(widx_nxt) == nwords) state <= CSUM;
              end
            endcase
          end
        end

        CSUM: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERROR;
              error <= 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          if (start) begin
            state    <= HDR;
            bcnt     <= 2'd0;
            sum      <= 8'd0;
            widx     <= '0;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end

        default: begin
          state    <= INIT;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised boot-stream bench: expected writes go into a scoreboard queue, a monitor checks every we pulse.
module tb_imem_boot_loader;

  localparam int SIZE = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        start = 1'b0;
  logic        in_ready, we, cpu_hold, done, error;
  logic [31:0] waddr, wdata;

  imem_boot_loader #(.Size(SIZE)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .start(start), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] expq[$];
  logic [31:0] img[$];
  logic [63:0] exp_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (reset_n && we) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_we: waddr 0x%0h wdata 0x%0h, expected no write", waddr, wdata);
      end else begin
        exp_w = expq.pop_front();
        chk("waddr", waddr, exp_w[63:32]);
        chk("wdata", wdata, exp_w[31:0]);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge right after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int w;
    in_valid = 1'b0;
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, expected 1", w);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic with_valid);
    start    = 1'b1;
    in_valid = with_valid;
    in_data  = 8'hA5;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    chk("start_ready", in_ready, 1);
    chk("start_hold", cpu_hold, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
  endtask

  // Reference: image in img, header value n; expected writes and outcome derived from the stream rules.
  task automatic run_load(input logic [31:0] n, input logic bad, input int maxgap);
    logic [7:0]  sum;
    logic [31:0] w;
    logic [7:0]  cs;
    sum = 8'd0;
    if (n <= SIZE) begin
      for (int i = 0; i < img.size(); i++) begin
        w = img[i];
        sum = sum + w[7:0] + w[15:8] + w[23:16] + w[31:24];
        expq.push_back({32'(i * 4), w});
      end
    end
    for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], maxgap);
    if (n > SIZE) begin
      chk("ovr_error", error, 1);
      chk("ovr_ready", in_ready, 0);
      chk("ovr_hold", cpu_hold, 1);
      chk("ovr_done", done, 0);
      repeat (4) @(negedge clk);
      return;
    end
    chk("load_hold", cpu_hold, 1);
    chk("load_done", done, 0);
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], maxgap);
    end
    cs = bad ? sum + 8'd1 : sum;
    send_byte(cs, maxgap);
    chk("end_done", done, !bad);
    chk("end_error", error, bad);
    chk("end_hold", cpu_hold, bad);
    chk("end_ready", in_ready, 0);
    chk("writes_seen", expq.size(), 0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("init_ready", in_ready, 0);
    @(negedge clk);
    chk("first_ready", in_ready, 1);

    // Normal load
    img = '{32'h00000013, 32'h00100093};
    run_load(32'd2, 1'b0, 0);
    // Checksum mismatch (B7), start coinciding with a valid byte that must not transfer
    do_start(1'b1);
    img = '{32'h00000013, 32'h00100093};
    run_load(32'd2, 1'b1, 0);
    // Empty image, good and bad checksum
    do_start(1'b0);
    img = {};
    run_load(32'd0, 1'b0, 0);
    do_start(1'b0);
    run_load(32'd0, 1'b1, 0);
    // Oversize by one word
    do_start(1'b0);
    run_load(32'd1025, 1'b0, 0);
    // Normal image with stalls
    do_start(1'b0);
    img = '{32'h00000013, 32'h00100093};
    run_load(32'd2, 1'b0, 3);
    // Random images
    for (int r = 0; r < 6; r++) begin
      int n;
      do_start(1'b0);
      n = $urandom_range(1, 8);
      img = {};
      for (int i = 0; i < n; i++) img.push_back($urandom);
      run_load(32'(n), 1'($urandom_range(0, 1)), 2);
    end
    // Largest legal image
    do_start(1'b0);
    img = {};
    for (int i = 0; i < SIZE; i++) img.push_back($urandom);
    run_load(32'(SIZE), 1'b0, 0);
    // Reset between payload bytes 5 and 6
    do_start(1'b0);
    expq.push_back({32'h0, 32'h00000013});
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_hold", cpu_hold, 1);
    chk("midrst_writes", expq.size(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    img = '{32'h00000013, 32'h00100093};
    run_load(32'd2, 1'b0, 1);
    // Reload after DONE
    do_start(1'b0);
    img = '{32'h0000006F};
    run_load(32'd1, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("final_queue", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Writes a program image into the instruction memory from a byte stream, so the fetch stage can read it at run time. It holds the core in reset until the image is loaded. It takes a little-endian, length-prefixed, checksummed byte stream over a valid/ready handshake. It assembles each group of four bytes into a 32-bit instruction word and issues one write per word on the instruction memory's write port, at word-aligned byte addresses starting at 0. It sits between the boot byte source (UART receiver or testbench) and the instruction memory. Its `cpu_hold` output drives the core's fetch reset.

## Interface
- `Size`, default 1024: instruction memory depth in 32-bit words. Images longer than this are rejected.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: `in_data` holds a byte.
- `in_data` input 8: stream byte.
- `in_ready` output 1: loader can accept a byte. A byte transfers on a rising edge with `in_valid && in_ready`.
- `start` input 1: single-cycle pulse that restarts a load from DONE or ERROR.
- `we` output 1: instruction memory write strobe, one cycle per word.
- `waddr` output 32: byte address of the write, always word-aligned.
- `wdata` output 32: instruction word.
- `cpu_hold` output 1: holds the core in reset; high except in DONE.
- `done` output 1: image loaded and checksum matched.
- `error` output 1: image rejected.

## Operation
- Stream format:
  - 4 header bytes: word count N, little-endian, 32-bit unsigned.
  - 4·N payload bytes, each word little-endian.
  - 1 checksum byte: sum of all payload bytes mod 256. Header bytes are excluded.
- Every state below is Moore; outputs depend only on the current state.
- INIT (reset state): `in_ready`=0. Moves to HDR unconditionally on the next edge.
- HDR: `in_ready`=1. A 2-bit byte counter places byte k at bits [8k+7:8k]. On the 4th accepted byte:
  - N > Size (32-bit unsigned compare): go to ERROR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA. Clear the word index and the running sum.
- DATA: `in_ready`=1.
  - Each accepted byte is added to the 8-bit running sum (wraps) and placed into the assembly register by the byte counter.
  - On the 4th byte of a word, register the write: `wdata`=assembled word, `waddr`={word index, 2'b00} zero-extended to 32 bits. Then increment the word index.
  - When the word index reaches N, go to CSUM.
- CSUM: `in_ready`=1. On the accepted byte, go to DONE if it equals the running sum, otherwise to ERROR.
- DONE: `in_ready`=0, `done`=1, `cpu_hold`=0.
- ERROR: `in_ready`=0, `error`=1, `cpu_hold`=1.
- `start` in DONE or ERROR goes to HDR and clears the counters, the sum and the word index. `start` in any other state is ignored.
- Word index width: clog2(Size)+1 bits.
- Words already written are never rolled back on ERROR or on reset.

## Timing
- Reset values (asynchronous, while `reset_n`=0):
  - state=INIT, `in_ready`=0, `we`=0, `waddr`=0, `wdata`=0.
  - `cpu_hold`=1, `done`=0, `error`=0.
- `in_ready` first goes high one cycle after `reset_n` deasserts.
- `we` is high for exactly the one cycle after the edge that accepts a word's 4th byte, with `waddr`/`wdata` valid in that cycle. Otherwise `we`=0.
- `we` may coincide with acceptance of the next byte. This includes the cycle after the final payload byte, when the state is already CSUM.
- Idle cycles (`in_valid`=0) leave all counters and the sum unchanged. There is no timeout.
- `done` rises and `cpu_hold` falls in the same cycle: the cycle after the checksum byte is accepted.
- `error` rises in the cycle after the rejecting byte is accepted: the 4th header byte, or the checksum byte.
- `reset_n` asserted mid-load forces all reset values immediately. This includes dropping a pending `we`. The next load begins from the header.
- `start` coinciding with `in_valid`: the state is DONE or ERROR, so `in_ready`=0 and no byte transfers that cycle.

## Test plan
- Normal load:
  - Stimulus: reset, then bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00 | B6.
  - Response: `we` pulse with `waddr`=0x0, `wdata`=0x00000013; `we` pulse with `waddr`=0x4, `wdata`=0x00100093; then `done`=1, `cpu_hold`=0, `in_ready`=0.
- Checksum mismatch:
  - Stimulus: same stream with final byte B7.
  - Response: both writes still occur, then `error`=1, `cpu_hold`=1, `done`=0.
- Empty image:
  - Stimulus: 00 00 00 00 | 00.
  - Response: no `we`; `done`=1. Using final byte 01 instead gives `error`=1.
- Oversize image:
  - Stimulus: header 01 04 00 00 (N=1025) with Size=1024.
  - Response: `error`=1 in the cycle after the 4th header byte; `in_ready`=0; no `we` ever.
- Stalls and reset:
  - Stimulus: normal image with random `in_valid` gaps.
  - Response: same writes and `done` as the normal load.
  - Stimulus: `reset_n` low between payload bytes 5 and 6.
  - Response: `we`=0 and `in_ready`=0 immediately. A full restarted load then succeeds.
- Reload:
  - Stimulus: after DONE, pulse `start`, then 01 00 00 00 | 6F 00 00 00 | 6F.
  - Response: `cpu_hold`=1 during the load; one write with `waddr`=0, `wdata`=0x0000006F; `done`=1 again.
